// File: rtl/kyber_pkg.sv
// -----------------------------------------------------------------------------
// kyber_pkg
// Shared constants and helpers for the Kyber coefficient decode, encode and
// decompress stages.
//   KYBER_Q / KYBER_N  : modulus and coefficients per polynomial
//   L_*                : legal field-width encodings for ByteDecode_l
//   fields_per_word(l) : number of l-bit fields packed into one 64-bit word
//   dec_state_t        : control states of the decompress stage
// -----------------------------------------------------------------------------
package kyber_pkg;

    localparam int KYBER_Q = 3329;
    localparam int KYBER_N = 256;

    localparam logic [3:0] L_1  = 4'd1;
    localparam logic [3:0] L_4  = 4'd4;
    localparam logic [3:0] L_5  = 4'd5;
    localparam logic [3:0] L_10 = 4'd10;
    localparam logic [3:0] L_11 = 4'd11;
    localparam logic [3:0] L_12 = 4'd12;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } dec_state_t;

    // Unsupported widths fall back to the l=12 packing.
    function automatic logic [6:0] fields_per_word(input logic [3:0] l);
        case (l)
            L_1:     return 7'd64;
            L_4:     return 7'd16;
            L_5:     return 7'd12;
            L_10:    return 7'd6;
            L_11:    return 7'd5;
            default: return 7'd5;
        endcase
    endfunction

endpackage

// File: rtl/decompress_unit.sv
// -----------------------------------------------------------------------------
// decompress_unit
// Combinational Decompress_d: y = round(Q * x / 2^l) for l < 12, passthrough
// for l = 12 (and for any width outside 1..11).
// Ports:
//   i_x [11:0]  right-aligned l-bit field value
//   i_l [3:0]   field width
//   o_y [11:0]  decompressed coefficient
// -----------------------------------------------------------------------------
module decompress_unit
    import kyber_pkg::*;
#(
    parameter int Q = KYBER_Q
) (
    input  logic [11:0] i_x,
    input  logic [3:0]  i_l,
    output logic [11:0] o_y
);

    logic [23:0] w_prod;
    logic [23:0] w_rnd;
    logic [23:0] w_sum;

    always_comb begin
        // Q * (2^11 - 1) still fits in 23 bits, so the 24-bit sum never overflows.
        w_prod = 24'(Q) * {12'd0, i_x};
        w_rnd  = '0;
        w_sum  = w_prod;
        o_y    = i_x;
        if (i_l != 4'd0 && i_l < 4'd12) begin
            w_rnd = 24'd1 << (i_l - 4'd1);
            w_sum = w_prod + w_rnd;
            o_y   = 12'(w_sum >> i_l);
        end
    end

endmodule

// File: rtl/coeff_decompress.sv
// -----------------------------------------------------------------------------
// coeff_decompress
// Unpacks 64-bit ByteDecode_l words (fields MSB-aligned) into one 12-bit
// decompressed coefficient per cycle, stopping after N_COEF coefficients and
// pulsing o_done once the final one has been taken downstream.
// Optional feature macro: DECOMP_RANGE_CHECK_EN (sticky o_err on l=12, x >= Q).
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_l                 field width, latched with the first word of a polynomial
//   i_coeffs/_valid     packed input word, o_coeffs_ready handshake
//   o_coeff/_valid      output coefficient, i_coeff_ready handshake
//   o_last              marks coefficient N_COEF-1
//   o_done              1-cycle pulse after the last coefficient is accepted
//   o_err               sticky range error (0 when the check is compiled out)
// -----------------------------------------------------------------------------
module coeff_decompress
    import kyber_pkg::*;
#(
    parameter int DW     = 64,
    parameter int CW     = 12,
    parameter int Q      = KYBER_Q,
    parameter int N_COEF = KYBER_N
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [3:0]    i_l,
    input  logic [DW-1:0] i_coeffs,
    input  logic          i_coeffs_valid,
    output logic          o_coeffs_ready,
    output logic [CW-1:0] o_coeff,
    output logic          o_coeff_valid,
    input  logic          i_coeff_ready,
    output logic          o_last,
    output logic          o_done,
    output logic          o_err
);

    localparam logic [7:0] LAST_IDX = 8'(N_COEF - 1);

    dec_state_t    r_state;
    dec_state_t    w_next;

    // Word register holds the current word pre-shifted so the next field is at the top.
    logic [DW-1:0] r_word;
    logic          r_full;
    logic [6:0]    r_fidx;
    logic [3:0]    r_l;
    logic [7:0]    r_cnt;
    logic          r_hold;   // last coefficient issued, waiting for it to drain

    logic [CW-1:0] r_coeff;
    logic          r_coeff_valid;
    logic          r_last;

    logic          w_active;
    logic [3:0]    w_l;
    logic [6:0]    w_fpw;
    logic          w_out_free;
    logic          w_ready;
    logic          w_take;
    logic [DW-1:0] w_src_word;
    logic [6:0]    w_src_fidx;
    logic          w_issue;
    logic          w_is_last;
    logic          w_word_end;
    logic [3:0]    w_sh;
    logic [CW-1:0] w_x;
    logic [CW-1:0] w_y;

    // ---------------- datapath control ----------------
    always_comb begin
        w_active   = ((r_state == S_IDLE) || (r_state == S_RUN)) && !r_hold;
        // First word of a polynomial is decoded with the live i_l; later ones use the latch.
        w_l        = (r_state == S_IDLE) ? i_l : r_l;
        w_fpw      = fields_per_word(w_l);
        w_out_free = !r_coeff_valid || i_coeff_ready;
        w_is_last  = (r_cnt == LAST_IDX);
        w_ready    = w_active &&
                     (!r_full || (w_out_free && (r_fidx == w_fpw - 7'd1) && !w_is_last));
        w_take     = i_coeffs_valid && w_ready;
        // An empty word register lets an arriving word feed the output register directly.
        w_src_word = r_full ? r_word : i_coeffs;
        w_src_fidx = r_full ? r_fidx : 7'd0;
        w_issue    = w_active && w_out_free && (r_full || w_take);
        w_word_end = (w_src_fidx == w_fpw - 7'd1) || w_is_last;
        w_sh       = (w_l == 4'd0 || w_l > 4'd12) ? 4'd0 : (4'd12 - w_l);
        w_x        = w_src_word[DW-1 -: CW] >> w_sh;
    end

    decompress_unit #(.Q(Q)) u_decomp (
        .i_x (w_x),
        .i_l (w_l),
        .o_y (w_y)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        o_done = 1'b0;
        case (r_state)
            S_IDLE: if (w_take) w_next = S_RUN;
            S_RUN:  if (r_coeff_valid && r_last && i_coeff_ready) w_next = S_DONE;
            S_DONE: begin
                o_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // ---------------- word register ----------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_word <= '0;
            r_full <= 1'b0;
            r_fidx <= '0;
            r_l    <= '0;
        end else begin
            if (r_state == S_IDLE && w_take) r_l <= i_l;
            if (w_issue) begin
                if (w_word_end) begin
                    // Back-to-back refill; a word cut short by the final coefficient is dropped.
                    if (w_take && r_full) begin
                        r_word <= i_coeffs;
                        r_fidx <= '0;
                        r_full <= 1'b1;
                    end else begin
                        r_full <= 1'b0;
                    end
                end else begin
                    r_word <= w_src_word << w_l;
                    r_fidx <= w_src_fidx + 7'd1;
                    r_full <= 1'b1;
                end
            end else if (w_take) begin
                r_word <= i_coeffs;
                r_fidx <= '0;
                r_full <= 1'b1;
            end
        end
    end

    // ---------------- output register and counters ----------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_coeff       <= '0;
            r_coeff_valid <= 1'b0;
            r_last        <= 1'b0;
            r_cnt         <= '0;
            r_hold        <= 1'b0;
        end else begin
            if (w_issue) begin
                r_coeff       <= w_y;
                r_coeff_valid <= 1'b1;
                r_last        <= w_is_last;
                r_cnt         <= r_cnt + 8'd1;   // wraps to 0 after the last index
            end else if (i_coeff_ready) begin
                r_coeff_valid <= 1'b0;
                r_last        <= 1'b0;
            end
            if (w_issue && w_is_last)  r_hold <= 1'b1;
            else if (r_state == S_DONE) r_hold <= 1'b0;
        end
    end

`ifdef DECOMP_RANGE_CHECK_EN
    logic w_range_bad;
    logic r_err;

    assign w_range_bad = (w_l == L_12) && (w_x >= CW'(Q));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_err <= 1'b0;
        end else if (r_state == S_IDLE && w_take) begin
            r_err <= w_issue && w_range_bad;   // new polynomial restarts the flag
        end else if (w_issue && w_range_bad) begin
            r_err <= 1'b1;
        end
    end

    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

    // Ready is forced low while reset is held so every output reads 0 in reset.
    assign o_coeffs_ready = w_ready && !i_rst;
    assign o_coeff        = r_coeff;
    assign o_coeff_valid  = r_coeff_valid;
    assign o_last         = r_last;

endmodule
